warmboot_sequencer: RTL and testbench

- Sequences the hand-off from the USB bootloader to a user image through the iCE40 SB_WARMBOOT primitive.
- On a boot request it performs these steps in order:
  - quiesces the SPI flash master;
  - detaches from USB by dropping the pull-up long enough for the host to see a disconnect;
  - holds the image-select lines stable;
  - asserts BOOT.
- Sits between tinyfpga_bootloader (requester, SPI master) and the board top (pin_pu, SB_WARMBOOT).

---
 rtl/boot_pkg.sv | 39 +++
 rtl/boot_timer.sv | 37 +++
 rtl/warmboot_sequencer.sv | 150 +++++++++++++++
 tb/tb_warmboot_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and defaults for the warm-boot hand-off: FSM state encoding,
// image indices, default interval lengths and the registered-output bundle.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        DETACH,
        SETUP,
        BOOT
    } boot_state_e;

    localparam logic [1:0] IMG_BOOTLOADER = 2'b00;
    localparam logic [1:0] IMG_USER       = 2'b01;

    localparam int DEF_DETACH_CYCLES   = 48000;
    localparam int DEF_SETUP_CYCLES    = 4;
    localparam int DEF_QUIESCE_TIMEOUT = 4096;
    localparam int DEF_AUTOBOOT_CYCLES = 48000000;

    typedef struct packed {
        logic busy;
        logic spi_hold;
        logic usb_pu;
        logic s1;
        logic s0;
        logic boot;
        logic timeout;
    } boot_out_t;

    // Pull-up on, everything else low: the attached, idle bootloader.
    localparam boot_out_t OUT_RESET = '{busy: 1'b0, spi_hold: 1'b0, usb_pu: 1'b1,
                                       s1: 1'b0, s0: 1'b0, boot: 1'b0, timeout: 1'b0};

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/boot_timer.sv
// Interval timer shared by every sequencer phase: cleared on phase entry,
// counts enabled cycles and flags the cycle in which the count equals limit_i.
module boot_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign done_o = en_i && (count_q == limit_i);

    always_comb begin
        // NOTE: assign the default before any branch so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/warmboot_sequencer.sv
// Bootloader-to-user-image hand-off via SB_WARMBOOT: quiesce SPI, detach USB,
// settle S1/S0, assert BOOT. Define WARMBOOT_SEQ_AUTOBOOT_EN for idle auto-boot.
module warmboot_sequencer
    import boot_pkg::*;
#(
    parameter int DETACH_CYCLES   = DEF_DETACH_CYCLES,
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int QUIESCE_TIMEOUT = DEF_QUIESCE_TIMEOUT,
    parameter int AUTOBOOT_CYCLES = DEF_AUTOBOOT_CYCLES
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    input  logic       spi_busy,
    input  logic       usb_activity,
    output logic       busy,
    output logic       spi_hold,
    output logic       usb_pu,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       timeout_flag
);

    localparam int CNT_MAX = max_of(max_of(DETACH_CYCLES, SETUP_CYCLES),
                                    max_of(QUIESCE_TIMEOUT, AUTOBOOT_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LIM_QUIESCE = CNT_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LIM_DETACH  = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_SETUP   = CNT_W'(SETUP_CYCLES - 1);

    boot_state_e      state_q, state_d;
    logic [1:0]       img_q, img_d;
    boot_out_t        out_q, out_d;
    logic             tmr_clear, tmr_en, tmr_done;
    logic [CNT_W-1:0] tmr_limit;
    logic             start;
    logic [1:0]       start_img;

    boot_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk     (clk_48mhz),
        .reset   (reset),
        .clear_i (tmr_clear),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .done_o  (tmr_done)
    );

`ifdef WARMBOOT_SEQ_AUTOBOOT_EN
    localparam logic [CNT_W-1:0] LIM_AUTO = CNT_W'(AUTOBOOT_CYCLES - 1);
`else
    logic unused_activity;
    assign unused_activity = usb_activity;
`endif

    always_comb begin
        state_d   = state_q;
        img_d     = img_q;
        out_d     = out_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b1;
        tmr_limit = LIM_DETACH;
        start     = 1'b0;
        start_img = boot_image;

        case (state_q)
            IDLE: begin
`ifdef WARMBOOT_SEQ_AUTOBOOT_EN
                // Explicit request beats activity, activity beats the idle timeout.
                tmr_limit = LIM_AUTO;
                if (boot_req) begin
                    start = 1'b1;
                end else if (usb_activity) begin
                    tmr_clear = 1'b1;
                end else if (tmr_done) begin
                    start     = 1'b1;
                    start_img = IMG_USER;
                end
`else
                tmr_en = 1'b0;
                start  = boot_req;
`endif
                if (start) begin
                    state_d        = QUIESCE;
                    img_d          = start_img;
                    tmr_clear      = 1'b1;
                    out_d.busy     = 1'b1;
                    out_d.spi_hold = 1'b1;
                    out_d.timeout  = 1'b0;
                end
            end
            QUIESCE: begin
                tmr_limit = LIM_QUIESCE;
                if (!spi_busy || tmr_done) begin
                    state_d       = DETACH;
                    tmr_clear     = 1'b1;
                    out_d.usb_pu  = 1'b0;
                    out_d.timeout = spi_busy;
                end
            end
            DETACH: begin
                if (tmr_done) begin
                    state_d   = SETUP;
                    tmr_clear = 1'b1;
                    out_d.s1  = img_q[1];
                    out_d.s0  = img_q[0];
                end
            end
            SETUP: begin
                tmr_limit = LIM_SETUP;
                if (tmr_done) begin
                    state_d    = BOOT;
                    tmr_clear  = 1'b1;
                    out_d.boot = 1'b1;
                end
            end
            BOOT: begin
                tmr_en = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q <= IDLE;
            img_q   <= IMG_BOOTLOADER;
            out_q   <= OUT_RESET;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            out_q   <= out_d;
        end
    end

    assign busy         = out_q.busy;
    assign spi_hold     = out_q.spi_hold;
    assign usb_pu       = out_q.usb_pu;
    assign wb_s1        = out_q.s1;
    assign wb_s0        = out_q.s0;
    assign wb_boot      = out_q.boot;
    assign timeout_flag = out_q.timeout;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Randomized scoreboard bench for warmboot_sequencer; the reference model tracks
// the sequence as an offset from the accepted request and derives outputs arithmetically.
`timescale 1ns/1ps
module tb_warmboot_sequencer;

    localparam int D  = 10;
    localparam int S  = 4;
    localparam int QT = 16;
    localparam int AB = 50;

    logic       clk_48mhz    = 1'b0;
    logic       reset        = 1'b1;
    logic       boot_req     = 1'b0;
    logic [1:0] boot_image   = 2'b00;
    logic       spi_busy     = 1'b0;
    logic       usb_activity = 1'b0;
    logic       busy, spi_hold, usb_pu, wb_s1, wb_s0, wb_boot, timeout_flag;

    warmboot_sequencer #(
        .DETACH_CYCLES   (D),
        .SETUP_CYCLES    (S),
        .QUIESCE_TIMEOUT (QT),
        .AUTOBOOT_CYCLES (AB)
    ) dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .boot_req     (boot_req),
        .boot_image   (boot_image),
        .spi_busy     (spi_busy),
        .usb_activity (usb_activity),
        .busy         (busy),
        .spi_hold     (spi_hold),
        .usb_pu       (usb_pu),
        .wb_s1        (wb_s1),
        .wb_s0        (wb_s0),
        .wb_boot      (wb_boot),
        .timeout_flag (timeout_flag)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    typedef struct packed {
        int         cyc;
        logic [7:0] scen;
        logic [6:0] v;     // {busy, spi_hold, usb_pu, s1, s0, boot, timeout}
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   scen  = 0;

    // Reference model: m_t is cycles since the accepted request, m_lq the
    // offset of the last QUIESCE cycle (-1 while still quiescing).
    bit         m_active = 1'b0;
    int         m_t      = 0;
    int         m_lq     = -1;
    int         m_idle   = 0;
    logic [1:0] m_img    = 2'b00;
    logic       m_to     = 1'b0;

    function automatic void model_step(input logic rst, input logic req, input logic [1:0] img,
                                       input logic spi, input logic act);
        bit         go;
        logic [1:0] gimg;
        go   = 1'b0;
        gimg = img;
        if (rst) begin
            m_active = 1'b0;
            m_idle   = 0;
            return;
        end
        if (!m_active) begin
            if (req) begin
                go = 1'b1;
            end
`ifdef WARMBOOT_SEQ_AUTOBOOT_EN
            else if (!act && m_idle == AB - 1) begin
                go   = 1'b1;
                gimg = 2'b01;
            end
`endif
            m_idle = (act || go) ? 0 : m_idle + 1;
            if (go) begin
                m_active = 1'b1;
                m_t      = 0;
                m_lq     = -1;
                m_to     = 1'b0;
                m_img    = gimg;
            end
        end else if (m_lq < 0) begin
            if (!spi) begin
                m_lq = m_t;
            end else if (m_t == QT) begin
                m_lq = m_t;
                m_to = 1'b1;
            end
        end
        if (m_active) m_t++;
    endfunction

    function automatic logic [6:0] model_out();
        int d;
        if (!m_active) return 7'b0010000;
        if (m_lq < 0 || m_t <= m_lq) return 7'b1110000;
        d = m_t - m_lq;
        if (d <= D) return {3'b110, 2'b00, 1'b0, m_to};
        if (d <= D + S) return {3'b110, m_img, 1'b0, m_to};
        return {3'b110, m_img, 1'b1, m_to};
    endfunction

    task automatic drive(input logic rst, input logic req, input logic [1:0] img,
                         input logic spi, input logic act);
        exp_t e;
        @(negedge clk_48mhz);
        reset        = rst;
        boot_req     = req;
        boot_image   = img;
        spi_busy     = spi;
        usb_activity = act;
        model_step(rst, req, img, spi, act);
        e.cyc  = cyc;
        e.scen = scen[7:0];
        e.v    = model_out();
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic reset_idle(input int gap);
        drive(1'b1, 1'b1, 2'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < gap; i++) begin
            drive(1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    // Request at offset 0, spi_busy high for offsets 1..spi_len, an optional second
    // request (image 2'b11) at req2_at and an optional reset at rst_at.
    task automatic run_seq(input logic [1:0] img, input int spi_len, input int n,
                           input int req2_at, input int rst_at, input bit noise);
        drive(1'b0, 1'b1, img, 1'b0, 1'b0);
        for (int k = 1; k <= n; k++) begin
            logic       r;
            logic [1:0] ri;
            logic       sp;
            r  = noise ? 1'($urandom_range(0, 3) == 0) : 1'(k == req2_at);
            ri = (k == req2_at) ? 2'b11 : 2'($urandom);
            sp = (k <= spi_len) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            drive(1'(k == rst_at), r, ri, sp, noise ? 1'($urandom) : 1'b0);
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(posedge clk_48mhz);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {busy, spi_hold, usb_pu, wb_s1, wb_s0, wb_boot, timeout_flag};
                n_vec++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL outputs scen=%0d cyc=%0d got=%b expected=%b (busy,hold,pu,s1,s0,boot,to)",
                             e.scen, e.cyc, got, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish in time, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin : stimulus
        scen = 0;
        reset_idle(2);

        scen = 1;  // basic boot, image 01, SPI idle
        reset_idle(3);
        run_seq(2'b01, 0, 20, 0, 0, 1'b0);

        scen = 2;  // SPI busy for 7 cycles, image 10
        reset_idle(2);
        run_seq(2'b10, 7, 28, 0, 0, 1'b0);

        scen = 3;  // SPI busy throughout: timeout path
        reset_idle(2);
        run_seq(2'b11, 1000, 40, 0, 0, 1'b0);

        scen = 4;  // ignored second request in DETACH, reset in SETUP, fresh boot
        reset_idle(2);
        run_seq(2'b10, 0, 13, 5, 13, 1'b0);
        run_seq(2'b01, 0, 20, 0, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            scen = 5 + i;
            reset_idle($urandom_range(0, 8));
            run_seq(2'($urandom), $urandom_range(0, 20), $urandom_range(18, 45),
                    $urandom_range(1, 30),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0,
                    1'($urandom));
        end

`ifdef WARMBOOT_SEQ_AUTOBOOT_EN
        scen = 20;  // autoboot with no activity
        reset_idle(0);
        for (int i = 0; i < 75; i++) drive(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        scen = 21;  // activity pulse at cycle 40 restarts the idle count
        reset_idle(0);
        for (int i = 0; i < 115; i++) drive(1'b0, 1'b0, 2'b10, 1'b0, 1'(i == 40));
`else
        scen = 20;  // no autoboot: long idle with random activity
        reset_idle(0);
        for (int i = 0; i < 200; i++) drive(1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
`endif

        repeat (3) @(posedge clk_48mhz);
        #2;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
